// File: rtl/sync_req_delay.sv
// -----------------------------------------------------------------------------
// sync_req_delay
//
// Delay element for a two-phase (transition-signalled) click pipeline.
// A request transition on inR is synchronised into the clk domain, held for
// DELAY clock edges, and then forwarded as a transition on outR. When the
// downstream acknowledge (outA) matches outR, the module completes the
// handshake by toggling inA back to the upstream stage.
//
// Parameters
//   DELAY        edges from leaving IDLE to the outR toggle (1..255)
//   SYNC_STAGES  flip-flops in each input synchroniser (2..4)
//
// Ports
//   clk   in   single clock, rising edge
//   rst   in   asynchronous reset, active low
//   inR   in   two-phase request from upstream (asynchronous)
//   inA   out  two-phase acknowledge to upstream
//   outR  out  two-phase delayed request to downstream
//   outA  in   two-phase acknowledge from downstream (asynchronous)
//   busy  out  high while a request is in flight (COUNT or WAIT_ACK)
//   err   out  sticky protocol-violation flag
// -----------------------------------------------------------------------------
module sync_req_delay #(
  parameter int unsigned DELAY       = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inR,
  output logic inA,
  output logic outR,
  input  logic outA,
  output logic busy,
  output logic err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNT    = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  localparam logic [7:0] LAST_CNT = 8'(DELAY - 1);

  logic [SYNC_STAGES-1:0] inr_sync_q;
  logic [SYNC_STAGES-1:0] outa_sync_q;
  logic                   inr_s;
  logic                   outa_s;

  state_e     state_q;
  logic [7:0] cnt_q;
  logic       req_phase_q;
  logic       ina_q;
  logic       outr_q;
  logic       busy_q;
  logic       err_q;
  logic       err_d;

  // Input synchronisers: the only logic that ever looks at inR / outA.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would
  // collapse the synchroniser chain into a single stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inr_sync_q  <= '0;
      outa_sync_q <= '0;
    end else begin
      inr_sync_q  <= {inr_sync_q[SYNC_STAGES-2:0], inR};
      outa_sync_q <= {outa_sync_q[SYNC_STAGES-2:0], outA};
    end
  end

  assign inr_s  = inr_sync_q[SYNC_STAGES-1];
  assign outa_s = outa_sync_q[SYNC_STAGES-1];

  // Protocol checks. An upstream transition while a request is in flight,
  // or a downstream acknowledge that does not answer an outstanding outR
  // toggle, is flagged; the flag only ever sets.
  // NOTE: err_d takes its held value first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    err_d = err_q;
    if ((state_q != IDLE) && (inr_s != req_phase_q)) begin
      err_d = 1'b1;
    end
    if ((state_q != WAIT_ACK) && (outa_s != outr_q)) begin
      err_d = 1'b1;
    end
  end

  // Handshake FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_phase_q <= 1'b0;
      ina_q       <= 1'b0;
      outr_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= err_d;
      case (state_q)
        IDLE: begin
          // Pending request: synchronised inR differs from our acknowledge.
          if (inr_s != ina_q) begin
            state_q     <= COUNT;
            cnt_q       <= '0;
            req_phase_q <= inr_s;
            busy_q      <= 1'b1;
          end
        end
        COUNT: begin
          // Edge k after leaving IDLE sees cnt == k-1, so the toggle lands
          // exactly DELAY edges later and cnt never exceeds DELAY-1.
          if (cnt_q == LAST_CNT) begin
            outr_q  <= ~outr_q;
            state_q <= WAIT_ACK;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        WAIT_ACK: begin
          if (outa_s == outr_q) begin
            ina_q   <= ~ina_q;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign inA  = ina_q;
  assign outR = outr_q;
  assign busy = busy_q;
  assign err  = err_q;

endmodule

// File: tb/tb_sync_req_delay.sv
// -----------------------------------------------------------------------------
// tb_sync_req_delay
//
// Self-checking bench for sync_req_delay. Three instances (DELAY = 5, 1, 255,
// SYNC_STAGES = 2) share clk and rst. A cycle-by-cycle vector table covers the
// basic DELAY=5 handshake; directed sequences cover protocol errors, reset
// mid-request, back-to-back requests and a long acknowledge stall.
// -----------------------------------------------------------------------------
module tb_sync_req_delay;

  logic clk;
  logic rst;

  logic in_r5,   in_a5,   out_r5,   out_a5,   busy5,   err5;
  logic in_r1,   in_a1,   out_r1,   out_a1,   busy1,   err1;
  logic in_r255, in_a255, out_r255, out_a255, busy255, err255;

  int n_checks = 0;
  int n_fail   = 0;

  sync_req_delay #(.DELAY(5), .SYNC_STAGES(2)) u_d5 (
    .clk(clk), .rst(rst), .inR(in_r5), .inA(in_a5),
    .outR(out_r5), .outA(out_a5), .busy(busy5), .err(err5)
  );

  sync_req_delay #(.DELAY(1), .SYNC_STAGES(2)) u_d1 (
    .clk(clk), .rst(rst), .inR(in_r1), .inA(in_a1),
    .outR(out_r1), .outA(out_a1), .busy(busy1), .err(err1)
  );

  sync_req_delay #(.DELAY(255), .SYNC_STAGES(2)) u_d255 (
    .clk(clk), .rst(rst), .inR(in_r255), .inA(in_a255),
    .outR(out_r255), .outA(out_a255), .busy(busy255), .err(err255)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic in_r;
    logic out_a;
    logic exp_in_a;
    logic exp_out_r;
    logic exp_busy;
    logic exp_err;
  } vec_t;

  vec_t vecs [12];

  int   n;
  int   tog_r;
  int   tog_a;
  logic prev_r;
  logic prev_a;
  logic ok;

  initial begin
    // Inputs applied before edge k, outputs expected after edge k.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};  // leaves IDLE
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};  // 5th edge: outR
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};  // outA echoes
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};  // inA follows
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b0;
    in_r5 = 1'b0;   out_a5 = 1'b0;
    in_r1 = 1'b0;   out_a1 = 1'b0;
    in_r255 = 1'b0; out_a255 = 1'b0;

    // ---------------- reset state, held across clock edges
    #1;
    check("reset_d5",   {in_a5, out_r5, busy5, err5}, 4'b0000);
    step(); step(); step();
    check("reset_hold_d5",  {in_a5, out_r5, busy5, err5}, 4'b0000);
    check("reset_hold_d1",  {in_a1, out_r1, busy1, err1}, 4'b0000);
    check("reset_hold_d255", {in_a255, out_r255, busy255, err255}, 4'b0000);
    rst = 1'b1;
    step();

    // ---------------- DELAY=5 basic handshake, vector table
    for (int i = 0; i < 12; i++) begin
      in_r5  = vecs[i].in_r;
      out_a5 = vecs[i].out_a;
      step();
      check($sformatf("vec%0d_{inA,outR,busy,err}", i),
            {in_a5, out_r5, busy5, err5},
            {vecs[i].exp_in_a, vecs[i].exp_out_r, vecs[i].exp_busy, vecs[i].exp_err});
    end

    // ---------------- extra inR transitions during COUNT
    in_r5 = 1'b0;
    n = 0;
    while (!busy5 && n < 10) begin step(); n++; end
    check("proto_busy", busy5, 1'b1);
    prev_r = out_r5;
    tog_r  = 0;
    in_r5 = 1'b1;  // upstream toggles before acknowledge ...
    step();
    in_r5 = 1'b0;  // ... and back again
    step();
    check("proto_err_not_yet", err5, 1'b0);
    step();
    check("proto_err_set", err5, 1'b1);
    n = 0;
    while (in_a5 != 1'b0 && n < 30) begin
      step(); n++;
      if (out_r5 != prev_r) begin tog_r++; prev_r = out_r5; end
      out_a5 = out_r5;
    end
    check("proto_ina_done", in_a5, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_r5 != prev_r) begin tog_r++; prev_r = out_r5; end
    end
    check("proto_one_outr_toggle", tog_r, 1);
    check("proto_idle_after", {busy5, err5}, 2'b01);

    // ---------------- reset on the 3rd COUNT cycle
    rst = 1'b0;
    out_a5 = 1'b0;
    step();
    check("rst2_err_cleared", err5, 1'b0);
    rst = 1'b1;
    step();
    in_r5 = 1'b1;
    n = 0;
    while (!busy5 && n < 10) begin step(); n++; end
    check("rst_req_busy", busy5, 1'b1);
    step(); step();                 // now in the 3rd COUNT cycle
    #2 rst = 1'b0;
    #1 check("rst_mid_immediate", {in_a5, out_r5, busy5, err5}, 4'b0000);
    step(); step(); step();
    check("rst_mid_held", {in_a5, out_r5, busy5, err5}, 4'b0000);
    rst = 1'b1;
    ok = 1'b1;
    n = 0;
    while (!busy5 && n < 10) begin
      step(); n++;
      if (out_r5 !== 1'b0) ok = 1'b0;
    end
    check("rst_fresh_busy", busy5, 1'b1);
    check("rst_no_stale_outr", ok, 1'b1);
    n = 0;
    while (out_r5 == 1'b0 && n < 20) begin step(); n++; end
    check("rst_fresh_latency", n, 5);
    out_a5 = 1'b1;
    n = 0;
    while (in_a5 == 1'b0 && n < 10) begin step(); n++; end
    check("rst_fresh_ina", {in_a5, out_r5, busy5, err5}, 4'b1100);

    // ---------------- spurious outA toggle while IDLE
    out_a5 = 1'b0;
    step(); step();
    check("spur_err_not_yet", err5, 1'b0);
    step();
    check("spur_err_set", err5, 1'b1);
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (busy5 !== 1'b0 || out_r5 !== 1'b1 || in_a5 !== 1'b1) ok = 1'b0;
    end
    check("spur_stays_idle", ok, 1'b1);
    check("spur_err_sticky", err5, 1'b1);

    // ---------------- DELAY=1, three back-to-back requests
    tog_r = 0; tog_a = 0;
    for (int k = 0; k < 3; k++) begin
      in_r1 = ~in_r1;
      n = 0;
      while (!busy1 && n < 10) begin step(); n++; end
      check($sformatf("b2b%0d_busy", k), busy1, 1'b1);
      prev_r = out_r1;
      n = 0;
      do begin step(); n++; end while (out_r1 == prev_r && n < 10);
      check($sformatf("b2b%0d_latency", k), n, 1);
      if (out_r1 != prev_r) tog_r++;
      prev_a = in_a1;
      out_a1 = out_r1;
      n = 0;
      while (in_a1 != in_r1 && n < 10) begin step(); n++; end
      if (in_a1 != prev_a) tog_a++;
      check($sformatf("b2b%0d_ina", k), in_a1, in_r1);
    end
    check("b2b_outr_toggles", tog_r, 3);
    check("b2b_ina_toggles", tog_a, 3);
    step(); step(); step();
    check("b2b_final", {in_a1, out_r1, busy1, err1}, 4'b1100);

    // ---------------- DELAY=255, long acknowledge stall
    in_r255 = 1'b1;
    n = 0;
    while (!busy255 && n < 10) begin step(); n++; end
    check("long_busy", busy255, 1'b1);
    n = 0;
    while (out_r255 == 1'b0 && n < 300) begin step(); n++; end
    check("long_latency", n, 255);
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (busy255 !== 1'b1 || in_a255 !== 1'b0 || out_r255 !== 1'b1) ok = 1'b0;
    end
    check("long_wait_hold", ok, 1'b1);
    out_a255 = 1'b1;
    n = 0;
    while (in_a255 == 1'b0 && n < 10) begin step(); n++; end
    check("long_ack_latency", n, 3);
    step();
    check("long_final", {in_a255, out_r255, busy255, err255}, 4'b1100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
